regfile_write_arbiter: RTL and testbench

//  Shares the register file's single write port (3:8-style enabled write decoder + regs) among
//  NUM_REQ requesters (ALU writeback, load unit, link/branch, debug). Round-robin arbitration,

---
 rtl/regfile_write_arbiter_pkg.sv | 23 ++
 rtl/regfile_write_arbiter_if.sv | 28 ++
 rtl/regfile_write_arbiter_rr_pick.sv | 29 ++
 rtl/regfile_write_arbiter.sv | 158 +++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and defaults for the register-file write-port arbiter.
// Build option: define ARB_LOCK_EN to enable locked multi-register bursts.
package regfile_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_t;

    localparam int DEFAULT_ADDR_W   = 5;
    localparam int DEFAULT_DATA_W   = 64;
    localparam int DEFAULT_ZERO_REG = 31;

    // Round-robin successor of idx among n requesters.
    function automatic int rr_next(input int idx, input int n);
        if (idx >= n - 1) begin
            return 0;
        end else begin
            return idx + 1;
        end
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Requester bundle plus register-file write port of the write arbiter.
// The arbiter uses the slave modport; requesters/observers use master.
interface regfile_write_arbiter_if
    import regfile_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int DATA_W  = DEFAULT_DATA_W
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_lock;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        gnt;
    logic                      wr_en;
    logic [ADDR_W-1:0]         wr_addr;
    logic [DATA_W-1:0]         wr_data;

    modport master (
        output req, req_lock, req_addr, req_data,
        input  gnt, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  req, req_lock, req_addr, req_data,
        output gnt, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/regfile_write_arbiter_rr_pick.sv
// Rotating priority encoder: first eligible index at or after ptr_i, wrapping.
// Produces a one-hot winner and a valid flag; purely combinational.
module rr_priority_pick #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     eligible_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     winner_o,
    output logic             valid_o
);
    logic [PTR_W-1:0] idx_s;

    // Scan from the pointer position; the first hit wins.
    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        idx_s    = '0;
        for (int k = 0; k < N; k++) begin
            idx_s = PTR_W'((int'(ptr_i) + k) % N);
            if (!valid_o && eligible_i[idx_s]) begin
                winner_o[idx_s] = 1'b1;
                valid_o         = 1'b1;
            end else begin
                valid_o = valid_o;
            end
        end
    end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file's single write port.
// Define ARB_LOCK_EN to allow a requester to hold the port for up to MAX_BURST grants.
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_W    = DEFAULT_ADDR_W,
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int ZERO_REG  = DEFAULT_ZERO_REG,
    parameter int MAX_BURST = 4
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    regfile_write_arbiter_if.slave  bus
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
`ifdef ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    arb_state_t         state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;

    logic [NUM_REQ-1:0] eligible_s;
    logic [NUM_REQ-1:0] pick_s;
    logic               pick_valid_s;
    logic [PTR_W-1:0]   win_idx_s;
    logic               sel_valid_s;
    logic [PTR_W-1:0]   sel_idx_s;
    logic [ADDR_W-1:0]  sel_addr_s;
    logic [DATA_W-1:0]  sel_data_s;
    logic               sel_lock_s;

    // A requester granted last cycle still shows its held payload; skip it once.
    assign eligible_s = bus.req & ~gnt_q;

    rr_priority_pick #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .eligible_i (eligible_s),
        .ptr_i      (ptr_q),
        .winner_o   (pick_s),
        .valid_o    (pick_valid_s)
    );

    // Encode the one-hot winner into an index.
    always_comb begin
        win_idx_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            win_idx_s = pick_s[i] ? PTR_W'(i) : win_idx_s;
        end
    end

    // Burst owner bypasses arbitration; otherwise the round-robin winner is served.
    always_comb begin
        if (state_q == ARB_BURST) begin
            sel_valid_s = bus.req[owner_q];
            sel_idx_s   = owner_q;
        end else begin
            sel_valid_s = pick_valid_s;
            sel_idx_s   = win_idx_s;
        end
    end

    assign sel_addr_s = bus.req_addr[int'(sel_idx_s)*ADDR_W +: ADDR_W];
    assign sel_data_s = bus.req_data[int'(sel_idx_s)*DATA_W +: DATA_W];
    assign sel_lock_s = LOCK_EN & bus.req_lock[sel_idx_s];

    // Next grant, write-port payload and burst FSM state.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        gnt_d     = '0;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        if (sel_valid_s) begin
            gnt_d = NUM_REQ'(1) << sel_idx_s;
            ptr_d = PTR_W'(rr_next(int'(sel_idx_s), NUM_REQ));
            // Writes to the zero register are granted but never reach the file.
            if (sel_addr_s != ADDR_W'(ZERO_REG)) begin
                wr_en_d   = 1'b1;
                wr_addr_d = sel_addr_s;
                wr_data_d = sel_data_s;
            end else begin
                wr_en_d = 1'b0;
            end
        end else begin
            gnt_d = '0;
        end

        case (state_q)
            ARB_IDLE: begin
                if (sel_valid_s && sel_lock_s) begin
                    state_d = ARB_BURST;
                    owner_d = sel_idx_s;
                    cnt_d   = CNT_W'(1);
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_BURST: begin
                if (sel_valid_s && sel_lock_s && (cnt_q + CNT_W'(1) != CNT_W'(MAX_BURST))) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    state_d = ARB_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= ARB_IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed + randomized bench for regfile_write_arbiter with a queue-free reference model.
// Honours ARB_LOCK_EN when the design is built with locked bursts.
module tb_regfile_write_arbiter;
    localparam int N  = 4;
    localparam int AW = 5;
    localparam int DW = 64;
    localparam int ZR = 31;
    localparam int MB = 4;
`ifdef ARB_LOCK_EN
    localparam bit LOCKED = 1'b1;
`else
    localparam bit LOCKED = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_write_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    regfile_write_arbiter #(
        .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ZERO_REG(ZR), .MAX_BURST(MB)
    ) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus.slave)
    );

    int tests = 0;
    int fails = 0;

    logic [N-1:0]  s_req, s_lock;
    logic [AW-1:0] s_addr [N];
    logic [DW-1:0] s_data [N];

    int  m_ptr, m_last, m_owner, m_cnt;
    bit  m_burst;
    logic [N-1:0]  e_gnt;
    logic          e_wr_en;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;

    task automatic drive();
        bus.req      = s_req;
        bus.req_lock = s_lock;
        for (int i = 0; i < N; i++) begin
            bus.req_addr[i*AW +: AW] = s_addr[i];
            bus.req_data[i*DW +: DW] = s_data[i];
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_last = -1; m_owner = 0; m_cnt = 0; m_burst = 1'b0;
        e_gnt = '0; e_wr_en = 1'b0; e_addr = '0; e_data = '0;
    endtask

    task automatic model_step();
        int g;
        g = -1;
        if (m_burst) begin
            if (s_req[m_owner]) begin
                g = m_owner;
                m_cnt = m_cnt + 1;
                m_ptr = (m_owner + 1) % N;
                if (!s_lock[m_owner] || m_cnt == MB) m_burst = 1'b0;
            end else begin
                m_burst = 1'b0;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (g < 0 && s_req[i] && i != m_last) g = i;
            end
            if (g >= 0) begin
                m_ptr = (g + 1) % N;
                if (LOCKED && s_lock[g]) begin
                    m_burst = 1'b1; m_owner = g; m_cnt = 1;
                end
            end
        end
        m_last  = g;
        e_gnt   = (g >= 0) ? (N'(1) << g) : '0;
        e_wr_en = 1'b0;
        if (g >= 0 && int'(s_addr[g]) != ZR) begin
            e_wr_en = 1'b1;
            e_addr  = s_addr[g];
            e_data  = s_data[g];
        end
    endtask

    task automatic check(input string tag);
        tests++;
        assert (bus.gnt === e_gnt) else begin
            fails++; $error("FAIL %s gnt got=%b exp=%b", tag, bus.gnt, e_gnt);
        end
        tests++;
        assert (bus.wr_en === e_wr_en) else begin
            fails++; $error("FAIL %s wr_en got=%b exp=%b", tag, bus.wr_en, e_wr_en);
        end
        tests++;
        assert (bus.wr_addr === e_addr) else begin
            fails++; $error("FAIL %s wr_addr got=%0d exp=%0d", tag, bus.wr_addr, e_addr);
        end
        tests++;
        assert (bus.wr_data === e_data) else begin
            fails++; $error("FAIL %s wr_data got=%h exp=%h", tag, bus.wr_data, e_data);
        end
    endtask

    task automatic cycle(input string tag);
        drive();
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        #1;
        check(tag);
    endtask

    task automatic want(input string tag, input logic [N-1:0] g, input logic en);
        tests++;
        assert (bus.gnt === g && bus.wr_en === en) else begin
            fails++; $error("FAIL %s gnt/wr_en got=%b/%b exp=%b/%b", tag, bus.gnt, bus.wr_en, g, en);
        end
    endtask

    logic [N-1:0] exp5 [5];

    initial begin
        model_reset();
        s_lock = '0;
        for (int i = 0; i < N; i++) begin
            s_addr[i] = AW'(i + 1);
            s_data[i] = DW'(64'h1000 + i);
        end

        // 1: reset held with all requests high
        s_req = 4'b1111;
        rst = 1'b1;
        cycle("rst0"); want("rst0_c", 4'b0000, 1'b0);
        cycle("rst1"); want("rst1_c", 4'b0000, 1'b0);
        rst = 1'b0;

        // 2: steady round-robin
        cycle("rr0"); want("rr0_c", 4'b0001, 1'b1);
        tests++;
        assert (bus.wr_addr === 5'd1) else begin
            fails++; $error("FAIL rr0_addr got=%0d exp=1", bus.wr_addr);
        end
        cycle("rr1"); want("rr1_c", 4'b0010, 1'b1);
        cycle("rr2"); want("rr2_c", 4'b0100, 1'b1);
        cycle("rr3"); want("rr3_c", 4'b1000, 1'b1);
        tests++;
        assert (bus.wr_addr === 5'd4) else begin
            fails++; $error("FAIL rr3_addr got=%0d exp=4", bus.wr_addr);
        end
        cycle("rr4"); want("rr4_c", 4'b0001, 1'b1);

        // 3: write to the zero register is granted but dropped
        s_req = 4'b0000;
        cycle("zr_idle");
        s_req = 4'b0100; s_addr[2] = 5'd31; s_data[2] = 64'hDEAD;
        cycle("zr"); want("zr_c", 4'b0100, 1'b0);
        tests++;
        assert (bus.wr_addr === 5'd1) else begin
            fails++; $error("FAIL zr_hold got=%0d exp=1", bus.wr_addr);
        end
        s_req = 4'b1111; s_addr[2] = 5'd3;
        cycle("zr_ptr"); want("zr_ptr_c", 4'b1000, 1'b1);

        // 4: single requester held -> every other cycle
        s_req = 4'b0000;
        cycle("m_idle");
        s_req = 4'b0010;
        cycle("m0"); want("m0_c", 4'b0010, 1'b1);
        cycle("m1"); want("m1_c", 4'b0000, 1'b0);
        cycle("m2"); want("m2_c", 4'b0010, 1'b1);
        cycle("m3"); want("m3_c", 4'b0000, 1'b0);

        // 5: locked burst capped at MAX_BURST, then the waiting requester
        rst = 1'b1; s_req = 4'b0000;
        cycle("b_rst");
        rst = 1'b0;
        s_req = 4'b1001; s_lock = 4'b0001;
        if (LOCKED) begin
            exp5[0] = 4'b0001; exp5[1] = 4'b0001; exp5[2] = 4'b0001; exp5[3] = 4'b0001; exp5[4] = 4'b1000;
        end else begin
            exp5[0] = 4'b0001; exp5[1] = 4'b1000; exp5[2] = 4'b0001; exp5[3] = 4'b1000; exp5[4] = 4'b0001;
        end
        for (int c = 0; c < 5; c++) begin
            cycle($sformatf("burst%0d", c));
            want($sformatf("burst%0d_c", c), exp5[c], 1'b1);
        end

        // 6: reset during the second burst cycle
        s_req = 4'b0000; s_lock = 4'b0000;
        cycle("r6_idle");
        s_req = 4'b0001; s_lock = 4'b0001;
        cycle("r6_g"); want("r6_g_c", 4'b0001, 1'b1);
        rst = 1'b1;
        cycle("r6_rst"); want("r6_rst_c", 4'b0000, 1'b0);
        tests++;
        assert (bus.wr_addr === 5'd0) else begin
            fails++; $error("FAIL r6_addr got=%0d exp=0", bus.wr_addr);
        end
        rst = 1'b0; s_req = 4'b1111; s_lock = 4'b0000;
        cycle("r6_after"); want("r6_after_c", 4'b0001, 1'b1);

        // Randomized traffic against the reference model
        for (int c = 0; c < 400; c++) begin
            rst    = ($urandom_range(0, 49) == 0);
            s_req  = N'($urandom);
            s_lock = N'($urandom);
            for (int i = 0; i < N; i++) begin
                s_addr[i] = ($urandom_range(0, 3) == 0) ? 5'd31 : AW'($urandom_range(0, 31));
                s_data[i] = {$urandom, $urandom};
            end
            cycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
